// File: rtl/serialize_word_to_bit_stream_pkg.sv
// Shared types for the word-to-bit-stream serializer and future framed-stream blocks.
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ser_state_t;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int ctr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serialize_word_to_bit_stream_if.sv
// Word handshake and serial bit stream bundled between producer, serializer and detector.
interface serialize_word_to_bit_stream_if #(
  parameter int W = 8
);

  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         a;
  logic         a_valid;
  logic         a_last;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  a,
    input  a_valid,
    input  a_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output a,
    output a_valid,
    output a_last
  );

endinterface

// File: rtl/serialize_word_to_bit_stream_hold_slot.sv
// One-entry word buffer in front of the shifter, with bypass when empty.
module serializer_hold_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         take,
  output logic         in_ready,
  output logic         full,
  output logic         avail,
  output logic [W-1:0] data
);

  logic         full_q, full_d;
  logic [W-1:0] hold_q, hold_d;
  logic         accept;

  assign in_ready = ~full_q & rst;
  assign accept   = in_valid & in_ready;
  assign full     = full_q;
  assign avail    = full_q | accept;
  assign data     = full_q ? hold_q : in_data;

  // A held word always wins the load slot; in_ready is low then, so no accept collides.
  always_comb begin
    full_d = full_q;
    hold_d = hold_q;
    if (take && full_q) begin
      full_d = 1'b0;
    end else if (accept && !take) begin
      full_d = 1'b1;
      hold_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= 1'b0;
      hold_q <= '0;
    end else begin
      full_q <= full_d;
      hold_q <= hold_d;
    end
  end

endmodule

// File: rtl/serialize_word_to_bit_stream.sv
// Parallel-to-serial stage: shifts W-bit words out MSB-first with an optional idle gap.
module serialize_word_to_bit_stream #(
  parameter int W   = 8,
  parameter int GAP = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  serialize_word_to_bit_stream_if.slave bus
);

  import serializer_pkg::*;

  localparam int            CW    = ctr_width(W);
  localparam int            GW    = ctr_width(GAP);
  localparam logic [CW-1:0] CLAST = CW'(W - 1);
  localparam logic [GW-1:0] GLAST = GW'((GAP > 0) ? GAP - 1 : 0);

  ser_state_t    state_q, state_d;
  logic [W-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;

  logic         load_slot;
  logic         slot_avail;
  logic         slot_full;
  logic [W-1:0] slot_data;

  serializer_hold_slot #(.W(W)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .in_valid (bus.in_valid),
    .in_data  (bus.in_data),
    .take     (load_slot),
    .in_ready (bus.in_ready),
    .full     (slot_full),
    .avail    (slot_avail),
    .data     (slot_data)
  );

  assign load_slot = (state_q == IDLE)
                   || ((state_q == SHIFT) && (cnt_q == CLAST) && (GAP == 0))
                   || ((state_q == serializer_pkg::GAP) && (gcnt_q == GLAST));

  // Free-running shift/gap progress; a load slot then overrides with the next word or IDLE.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    case (state_q)
      SHIFT: begin
        sr_d  = {sr_q[W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CLAST) begin
          cnt_d = '0;
          if (GAP > 0) begin
            state_d = serializer_pkg::GAP;
            gcnt_d  = '0;
          end
        end
      end
      serializer_pkg::GAP: begin
        gcnt_d = gcnt_q + 1'b1;
      end
      default: begin
      end
    endcase
    if (load_slot) begin
      if (slot_avail) begin
        state_d = SHIFT;
        sr_d    = slot_data;
        cnt_d   = '0;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
    end
  end

  assign bus.a       = (state_q == SHIFT) & sr_q[W-1];
  assign bus.a_valid = (state_q == SHIFT);
  assign bus.a_last  = (state_q == SHIFT) & (cnt_q == CLAST);

  logic unused_full;
  assign unused_full = slot_full;

endmodule
